// File: rtl/conf_shadow_regfile_if.sv
// Host-side bus of the configuration bank: shadow write port plus the commit handshake.
// The master drives requests; the slave (the register bank) answers with ready and ack.
interface conf_shadow_regfile_if #(
  parameter int ADDR_W     = 4,
  parameter int PORT_WIDTH = 32
);
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [ADDR_W-1:0]     wr_addr_i;
  logic [PORT_WIDTH-1:0] wr_data_i;
  logic                  commit_req_i;
  logic                  engine_busy_i;
  logic                  commit_ack_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, commit_req_i, engine_busy_i,
    input  wr_ready_o, commit_ack_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, commit_req_i, engine_busy_i,
    output wr_ready_o, commit_ack_o
  );
endinterface

// File: rtl/conf_shadow_regfile.sv
// Double-buffered configuration bank: host writes a shadow set, a commit copies it to the
// active set once the engine is idle. Optional shadow readback: CONF_SHADOW_READBACK_EN.
module conf_shadow_regfile #(
  parameter int N_REGS       = 16,
  parameter int REG_WIDTH    = 32,
  parameter int PORT_WIDTH   = 32,
  parameter int MODE_REG_IDX = 0,
  parameter int MODE_BITS    = 3,
  parameter int MODE_MAX     = 3,
  localparam int ADDR_W      = $clog2(N_REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  conf_shadow_regfile_if.slave        bus,
  output logic [N_REGS*REG_WIDTH-1:0] active_regs_o,
  output logic [MODE_BITS-1:0]        mode_o,
  output logic                        cfg_pending_o,
  output logic                        cfg_error_o
`ifdef CONF_SHADOW_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic [REG_WIDTH-1:0]        rd_data_o
`endif
);

  localparam logic [MODE_BITS-1:0] MODE_MAX_L = MODE_BITS'(MODE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COPY} state_t;

  state_t               state_q;
  logic                 wr_ready_q;
  logic                 ack_q;
  logic                 pending_q;
  logic                 error_q;
  logic [REG_WIDTH-1:0] shadow_q [N_REGS];
  logic [REG_WIDTH-1:0] active_q [N_REGS];

  logic wr_fire;
  logic wr_in_range;
  logic mode_ok;

  assign wr_fire = bus.wr_valid_i && wr_ready_q;
  assign mode_ok = (shadow_q[MODE_REG_IDX][MODE_BITS-1:0] <= MODE_MAX_L);

  // Address range checks only exist when N_REGS leaves unused address codes.
  if (N_REGS == (1 << ADDR_W)) begin : g_pow2
    assign wr_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = (32'(bus.wr_addr_i) < N_REGS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ready_q <= 1'b1;
      ack_q      <= 1'b0;
      pending_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (wr_fire) begin
        pending_q <= 1'b1;
        if (!wr_in_range) error_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.commit_req_i) begin
            state_q    <= bus.engine_busy_i ? S_WAIT : S_COPY;
            wr_ready_q <= bus.engine_busy_i;
          end
        end
        S_WAIT: begin
          if (!bus.engine_busy_i) begin
            state_q    <= S_COPY;
            wr_ready_q <= 1'b0;
          end
        end
        S_COPY: begin
          state_q    <= S_IDLE;
          wr_ready_q <= 1'b1;
          ack_q      <= 1'b1;
          if (mode_ok) begin
            pending_q <= 1'b0;
            error_q   <= 1'b0;
          end else begin
            error_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Writes are blocked in S_COPY, so the snapshot below never races a shadow update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_REGS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (wr_fire && wr_in_range) shadow_q[bus.wr_addr_i] <= bus.wr_data_i[REG_WIDTH-1:0];
      if (state_q == S_COPY && mode_ok) active_q <= shadow_q;
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_pack
    assign active_regs_o[k*REG_WIDTH +: REG_WIDTH] = active_q[k];
  end

  assign mode_o           = active_q[MODE_REG_IDX][MODE_BITS-1:0];
  assign cfg_pending_o    = pending_q;
  assign cfg_error_o      = error_q;
  assign bus.wr_ready_o   = wr_ready_q;
  assign bus.commit_ack_o = ack_q;

`ifdef CONF_SHADOW_READBACK_EN
  logic [REG_WIDTH-1:0] rd_data_q;
  logic                 rd_in_range;

  if (N_REGS == (1 << ADDR_W)) begin : g_rd_pow2
    assign rd_in_range = 1'b1;
  end else begin : g_rd_npow2
    assign rd_in_range = (32'(rd_addr_i) < N_REGS);
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_in_range ? shadow_q[rd_addr_i] : '0;
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_conf_shadow_regfile.sv
// Scoreboard bench for conf_shadow_regfile: a cycle-level behavioural model predicts each
// commit outcome into a queue, and a negedge monitor compares whenever the DUT acks.
module tb_conf_shadow_regfile;
  localparam int N = 16, RW = 32, PW = 32, MIDX = 0, MB = 3, MMAX = 3, AW = 4;
  localparam int W = N * RW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conf_shadow_regfile_if #(.ADDR_W(AW), .PORT_WIDTH(PW)) bus ();
  logic [W-1:0]  active_regs;
  logic [MB-1:0] mode;
  logic          pend_o, err_o;
`ifdef CONF_SHADOW_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_data;
  logic [RW-1:0] rd_exp;
`endif

  conf_shadow_regfile #(
    .N_REGS(N), .REG_WIDTH(RW), .PORT_WIDTH(PW),
    .MODE_REG_IDX(MIDX), .MODE_BITS(MB), .MODE_MAX(MMAX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .active_regs_o(active_regs), .mode_o(mode),
    .cfg_pending_o(pend_o), .cfg_error_o(err_o)
`ifdef CONF_SHADOW_READBACK_EN
    , .rd_addr_i(rd_addr), .rd_data_o(rd_data)
`endif
  );

  typedef struct {
    int            cyc;
    logic [W-1:0]  act;
    logic [MB-1:0] mode;
    logic          err;
    logic          pend;
  } exp_t;
  exp_t q[$];

  logic [RW-1:0] sh [N];
  logic [RW-1:0] act [N];
  bit pend, err, ready, outstanding, copy_next, armed;
  int cyc;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [W-1:0] pack_act();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*RW +: RW] = act[k];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Behavioural model of one clock edge, applied from the inputs held during that cycle.
  function automatic void model_edge();
    exp_t e;
    cyc++;
    if (reset) begin
      for (int k = 0; k < N; k++) begin sh[k] = '0; act[k] = '0; end
      pend = 0; err = 0; outstanding = 0; copy_next = 0; ready = 1;
      q.delete();
`ifdef CONF_SHADOW_READBACK_EN
      rd_exp = '0;
`endif
      return;
    end
`ifdef CONF_SHADOW_READBACK_EN
    rd_exp = sh[rd_addr];
`endif
    if (copy_next) begin
      copy_next = 0;
      if (int'(sh[MIDX] % (1 << MB)) <= MMAX) begin
        act = sh; pend = 0; err = 0;
      end else begin
        err = 1;
      end
      e.cyc = cyc; e.act = pack_act(); e.mode = act[MIDX][MB-1:0]; e.err = err; e.pend = pend;
      q.push_back(e);
    end else begin
      if (bus.wr_valid_i && ready) begin
        sh[bus.wr_addr_i] = bus.wr_data_i[RW-1:0];
        pend = 1;
      end
      if (outstanding || bus.commit_req_i) begin
        if (!bus.engine_busy_i) begin copy_next = 1; outstanding = 0; end
        else outstanding = 1;
      end
    end
    ready = !copy_next;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    armed = 1;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d;
    step();
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.commit_req_i = 1'b1;
    step();
    bus.commit_req_i = 1'b0;
  endtask

  // Monitor: continuous status checks plus scoreboard pop on every ack.
  always @(negedge clk) begin
    if (armed) begin
      exp_t e;
      chk("wr_ready", W'(bus.wr_ready_o), W'(ready));
      chk("pending", W'(pend_o), W'(pend));
      chk("error", W'(err_o), W'(err));
      chk("active", active_regs, pack_act());
`ifdef CONF_SHADOW_READBACK_EN
      chk("rd_data", W'(rd_data), W'(rd_exp));
`endif
      if (bus.commit_ack_o) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", W'(1), W'(0));
        end else begin
          e = q.pop_front();
          chk("ack_cycle", W'(cyc), W'(e.cyc));
          chk("ack_active", active_regs, e.act);
          chk("ack_mode", W'(mode), W'(e.mode));
          chk("ack_error", W'(err_o), W'(e.err));
          chk("ack_pending", W'(pend_o), W'(e.pend));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("missing_ack", W'(0), W'(1));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.wr_valid_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.commit_req_i = 1'b0; bus.engine_busy_i = 1'b0;
`ifdef CONF_SHADOW_READBACK_EN
    rd_addr = '0;
`endif
    run(2);
    reset = 1'b0;
    chk("reset_ready", W'(bus.wr_ready_o), W'(1));
    chk("reset_mode", W'(mode), W'(0));
    chk("reset_active", active_regs, W'(0));

    // Basic commit with the engine idle.
    wr(4'd0, 32'h1);
    wr(4'd5, 32'hDEAD_BEEF);
    commit_pulse();
    step();
    chk("t1_ack", W'(bus.commit_ack_o), W'(1));
    chk("t1_mode", W'(mode), W'(1));
    chk("t1_reg5", W'(active_regs[5*RW +: RW]), W'(32'hDEAD_BEEF));
    chk("t1_pending", W'(pend_o), W'(0));

    // Commit held off by a busy engine; writes during the wait are included.
    bus.engine_busy_i = 1'b1;
    commit_pulse();
    wr(4'd7, 32'h1234);
    run(8);
    chk("t2_reg7_held", W'(active_regs[7*RW +: RW]), W'(0));
    bus.engine_busy_i = 1'b0;
    step();
    chk("t2_no_ack_yet", W'(bus.commit_ack_o), W'(0));
    step();
    chk("t2_ack", W'(bus.commit_ack_o), W'(1));
    chk("t2_reg7", W'(active_regs[7*RW +: RW]), W'(32'h1234));

    // Illegal mode rejected, then a legal one clears the error.
    wr(4'd0, 32'h6);
    commit_pulse();
    step();
    chk("t3_err", W'(err_o), W'(1));
    chk("t3_mode_kept", W'(mode), W'(1));
    chk("t3_pending", W'(pend_o), W'(1));
    wr(4'd0, 32'h3);
    commit_pulse();
    step();
    chk("t3_err_clr", W'(err_o), W'(0));
    chk("t3_mode", W'(mode), W'(3));

    // Write together with the commit request; a write offered during the copy is refused.
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = 4'd9; bus.wr_data_i = 32'hCAFE;
    bus.commit_req_i = 1'b1;
    step();
    bus.commit_req_i = 1'b0;
    bus.wr_addr_i = 4'd10; bus.wr_data_i = 32'hBAD;
    chk("t4_ready_copy", W'(bus.wr_ready_o), W'(0));
    step();
    bus.wr_valid_i = 1'b0;
    chk("t4_reg9", W'(active_regs[9*RW +: RW]), W'(32'hCAFE));
    step();
    chk("t4_reg10_blocked", W'(active_regs[10*RW +: RW]), W'(0));

    // Reset during a pending commit aborts it.
    bus.engine_busy_i = 1'b1;
    commit_pulse();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.engine_busy_i = 1'b0;
    chk("t5_no_ack", W'(bus.commit_ack_o), W'(0));
    chk("t5_active", active_regs, W'(0));
    chk("t5_ready", W'(bus.wr_ready_o), W'(1));
    run(3);

`ifdef CONF_SHADOW_READBACK_EN
    wr(4'd3, 32'hA5);
    rd_addr = 4'd3;
    step();
    chk("t6_readback", W'(rd_data), W'(32'hA5));
`endif

    // Randomized traffic checked by the model and monitor.
    for (int i = 0; i < 600; i++) begin
      bus.wr_valid_i = 1'($urandom_range(0, 1));
      bus.wr_addr_i  = (($urandom % 4) == 0) ? 4'd0 : AW'($urandom);
      bus.wr_data_i  = (bus.wr_addr_i == 4'd0) ? PW'($urandom_range(0, 7)) : PW'($urandom);
      bus.commit_req_i = (($urandom % 6) == 0);
      if (($urandom % 6) == 0) bus.engine_busy_i = ~bus.engine_busy_i;
`ifdef CONF_SHADOW_READBACK_EN
      rd_addr = AW'($urandom);
`endif
      reset = (($urandom % 250) == 0);
      step();
    end
    reset = 1'b0;
    bus.wr_valid_i = 1'b0; bus.commit_req_i = 1'b0; bus.engine_busy_i = 1'b0;
    run(5);
    chk("queue_drained", W'(q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conf_shadow_regfile.md
# conf_shadow_regfile

Parametrised, double-buffered configuration register bank for the accelerator control unit. The host writes layer configuration words into a shadow set through the external 32-bit port while the engine runs. A commit handshake copies the shadow set into the active set only when the engine is idle, so a layer never sees a half-written configuration. The block also validates the mode field (FC/CNN/ACTIVATION/EWS) at commit time.

## Interface
- N_REGS, 16: number of configuration registers.
- REG_WIDTH, 32: register width; must be ≤ PORT_WIDTH (equals CONF_REGISTERS_SIZE).
- PORT_WIDTH, 32: external write port width (BIT_WIDTH_EXTERNAL_PORT).
- MODE_REG_IDX, 0: index of the register holding the mode field.
- MODE_BITS, 3: width of the mode field, located in bits [MODE_BITS-1:0].
- MODE_MAX, 3: highest legal mode code (MODE_EWS).

Ports:
- clk  in  1  clock; every flop is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accepted when wr_valid_i && wr_ready_o.
- wr_addr_i  in  $clog2(N_REGS)  shadow register index.
- wr_data_i  in  PORT_WIDTH  write data; the low REG_WIDTH bits are stored.
- commit_req_i  in  1  request to copy shadow → active.
- engine_busy_i  in  1  the engine is executing a layer.
- commit_ack_o  out  1  one-cycle pulse marking the end of a commit attempt.
- active_regs_o  out  N_REGS*REG_WIDTH  active set; register k occupies bits [k*REG_WIDTH +: REG_WIDTH].
- mode_o  out  MODE_BITS  mode field of the active set.
- cfg_pending_o  out  1  shadow holds writes not yet committed.
- cfg_error_o  out  1  sticky error flag.
- rd_addr_i  in  $clog2(N_REGS)  readback index (present only with the macro).
- rd_data_o  out  REG_WIDTH  readback data (present only with the macro).

## Operation
- FSM states: S_IDLE, S_WAIT, S_COPY.
  - S_IDLE: commit_req_i && !engine_busy_i → S_COPY. commit_req_i && engine_busy_i → S_WAIT.
  - S_WAIT: !engine_busy_i → S_COPY. commit_req_i is ignored here (requests merge).
  - S_COPY: always → S_IDLE after one cycle. commit_req_i is ignored here.
- wr_ready_o = 1 in S_IDLE and S_WAIT; 0 in S_COPY, so the snapshot is consistent.
- Accepted write:
  - shadow[wr_addr_i] ← wr_data_i[REG_WIDTH-1:0].
  - cfg_pending_o ← 1.
  - If wr_addr_i ≥ N_REGS (non-power-of-two N_REGS): data dropped, cfg_error_o ← 1.
- On the S_COPY edge, check m = shadow[MODE_REG_IDX][MODE_BITS-1:0].
  - m ≤ MODE_MAX: active ← shadow, cfg_pending_o ← 0, cfg_error_o ← 0.
  - m > MODE_MAX: active unchanged, cfg_pending_o stays 1, cfg_error_o ← 1.
  - commit_ack_o ← 1 in both cases.
- cfg_error_o is sticky. It clears only on a successful commit or on reset.
- mode_o = active[MODE_REG_IDX][MODE_BITS-1:0].

## Timing
- Reset:
  - All shadow and active registers = 0; FSM = S_IDLE.
  - commit_ack_o = 0, cfg_pending_o = 0, cfg_error_o = 0, mode_o = 0 (MODE_FC).
  - wr_ready_o = 1 from the first cycle after reset.
- Reset mid-S_WAIT or mid-S_COPY aborts the commit: no copy, no ack.
- Write latency: data lands in shadow at the accepting edge and is visible on readback the next cycle.
- Commit latency when idle: commit_req_i in cycle t → S_COPY in t+1 → active_regs_o updated and commit_ack_o high in t+2.
- With busy: the copy happens in the cycle after the first cycle in which engine_busy_i is low; the ack follows on the next cycle.
- A write accepted in the same cycle as commit_req_i (S_IDLE) is included in the copy.
- A write during S_WAIT is also included.
- Simultaneous write and successful commit: the write at the S_IDLE edge sets pending, and the commit clears it. Writes are blocked during S_COPY, so no conflict arises.

## Configuration
- CONF_SHADOW_READBACK_EN
  - Defined: rd_addr_i and rd_data_o exist. rd_data_o = shadow[rd_addr_i], registered with 1-cycle latency, and 0 for out-of-range addresses.
  - Undefined: the ports are absent and no readback mux is built.

## Test plan
- Reset, then write reg 0 = 0x1 and reg 5 = 0xDEAD_BEEF, then commit with busy low → ack in t+2, mode_o = 1, active reg 5 = 0xDEADBEEF, pending = 0.
- Hold busy high for 10 cycles and pulse commit_req_i → FSM in S_WAIT, active unchanged, writes still accepted; ack arrives 2 cycles after busy falls and includes those writes.
- Write reg 0 = 0x6 and commit → ack pulses, cfg_error_o = 1, active reg 0 keeps its old value, pending = 1; then write 0x3 and commit → error = 0, mode_o = 3.
- Write in the same cycle as commit_req_i → the written value appears in the active set; wr_ready_o = 0 during S_COPY.
- Assert reset during S_WAIT → no ack, all outputs 0, wr_ready_o = 1 the next cycle.
- With CONF_SHADOW_READBACK_EN defined: write reg 3 = 0xA5, read rd_addr_i = 3 → 0xA5 one cycle later.
